// File: rtl/ram_rsp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_rsp_pkg
// Description : Shared widths, response record and response-buffer depth
//               for the ram_req_responder memory responder.
//               AW/DW here fix the width of rsp_t; the top-level AW/DW
//               parameters must be left equal to these values.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_rsp_pkg;

   localparam int AW        = 4;   // address width
   localparam int DW        = 4;   // data width
   localparam int RSP_DEPTH = 2;   // response buffer entries

   // One response record: write flag and address echoed from the request,
   // plus the array contents seen before the access (read-first).
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] rdata;
   } rsp_t;

endpackage : ram_rsp_pkg
`default_nettype wire

// File: rtl/rsp_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : rsp_fifo2
// Description : Two-entry synchronous first-word-fall-through FIFO of rsp_t.
//               head always shows the oldest entry while count != 0.
// Ports       : clk        - clock
//               rst_n      - asynchronous active-low reset (pointers, count)
//               push       - write push_data at posedge
//               push_data  - entry to store
//               pop        - drop the head entry at posedge
//               head       - oldest entry (valid while empty == 0)
//               count      - current occupancy, 0..2
//               empty/full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module rsp_fifo2
   import ram_rsp_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push,
   input  rsp_t       push_data,
   input  logic       pop,
   output rsp_t       head,
   output logic [1:0] count,
   output logic       empty,
   output logic       full
);

   localparam logic [1:0] C_FULL_CNT = 2'(RSP_DEPTH);

   rsp_t       r_entry [RSP_DEPTH];
   logic       r_wptr;
   logic       r_rptr;
   logic [1:0] r_count;

   logic       w_do_pop;
   logic       w_do_push;

   // A push into a full FIFO is taken only when the head leaves on the
   // same edge; a pop of an empty FIFO is ignored.
   assign w_do_pop  = pop && (r_count != 2'd0);
   assign w_do_push = push && ((r_count != C_FULL_CNT) || w_do_pop);

   assign head  = r_entry[r_rptr];
   assign count = r_count;
   assign empty = (r_count == 2'd0);
   assign full  = (r_count == C_FULL_CNT);

   // Storage carries no reset: entries are only observed while count != 0.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_entry[r_wptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= 1'b0;
         r_rptr  <= 1'b0;
         r_count <= 2'd0;
      end else begin
         if (w_do_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : rsp_fifo2
`default_nettype wire

// File: rtl/ram_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_req_responder
// Description : Valid/ready memory-request responder. Owns a read-first
//               RAM array, registers one read stage and backs it with a
//               two-entry response FIFO so downstream stalls never drop
//               or reorder responses. One request per cycle while
//               rsp_ready is held high.
// Ports       : clk        - clock, all logic on posedge
//               rst_n      - asynchronous active-low reset
//               req_valid  - request present
//               req_ready  - request accepted when req_valid && req_ready
//               req_we     - 1 = write, 0 = read
//               req_addr   - access address
//               req_wdata  - write data (ignored for reads)
//               rsp_valid  - response present
//               rsp_ready  - response consumed when rsp_valid && rsp_ready
//               rsp_we     - echo of req_we
//               rsp_addr   - echo of req_addr
//               rsp_rdata  - array contents before the access
// Revision    : 1.0 - initial release
// ============================================================================
module ram_req_responder #(
   parameter int AW = ram_rsp_pkg::AW,   // must match ram_rsp_pkg::AW
   parameter int DW = ram_rsp_pkg::DW    // must match ram_rsp_pkg::DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic          rsp_we,
   output logic [AW-1:0] rsp_addr,
   output logic [DW-1:0] rsp_rdata
);

   import ram_rsp_pkg::*;

   localparam int         C_DEPTH   = 1 << AW;
   localparam logic [1:0] C_MAX_OUT = 2'(RSP_DEPTH);

   // Storage and read stage
   logic [DW-1:0] r_mem [C_DEPTH];
   rsp_t          r_stage;
   logic          r_inflight;

   // Response FIFO
   rsp_t          w_head;
   logic [1:0]    w_fifo_count;
   logic          w_fifo_empty;
   logic          w_fifo_full;
   logic          w_fifo_push;
   logic          w_fifo_pop;

   logic [1:0]    w_outstanding;
   logic          w_accept;
   logic          w_rsp_fire;
   rsp_t          w_rsp;

   // Outstanding work is held entirely in registers, so req_ready never
   // depends combinationally on rsp_ready.
   assign w_outstanding = {1'b0, r_inflight} + w_fifo_count;
   assign req_ready     = (w_outstanding < C_MAX_OUT);
   assign w_accept      = req_valid && req_ready;

   // The FIFO holds older responses than the read stage, so it has priority.
   assign rsp_valid  = !w_fifo_empty || r_inflight;
   assign w_rsp      = !w_fifo_empty ? w_head  :
                       r_inflight    ? r_stage : '0;
   assign rsp_we     = w_rsp.we;
   assign rsp_addr   = w_rsp.addr;
   assign rsp_rdata  = w_rsp.rdata;
   assign w_rsp_fire = rsp_valid && rsp_ready;

   assign w_fifo_pop  = w_rsp_fire && !w_fifo_empty;
   // The read stage is consumed directly only when it is the visible
   // response and the consumer takes it; otherwise it moves into the FIFO
   // so the stage is free for the next accepted request.
   assign w_fifo_push = r_inflight && !(w_fifo_empty && rsp_ready);

   // Array write: no reset, so contents survive rst_n.
   always_ff @(posedge clk) begin
      if (w_accept && req_we) begin
         r_mem[req_addr] <= req_wdata;
      end
   end

   // Read stage samples the array on the same edge as any write, which
   // yields the pre-write value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
         r_stage    <= '0;
      end else begin
         r_inflight <= w_accept;
         if (w_accept) begin
            r_stage.we    <= req_we;
            r_stage.addr  <= req_addr;
            r_stage.rdata <= r_mem[req_addr];
         end
      end
   end

   rsp_fifo2 u_rsp_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (w_fifo_push),
      .push_data (r_stage),
      .pop       (w_fifo_pop),
      .head      (w_head),
      .count     (w_fifo_count),
      .empty     (w_fifo_empty),
      .full      (w_fifo_full)
   );

   // Fullness is implied by the outstanding limit and needs no action here.
   logic w_unused;
   assign w_unused = w_fifo_full;

endmodule : ram_req_responder
`default_nettype wire

// File: tb/tb_ram_req_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_req_responder
// Description : Self-checking bench for ram_req_responder. Accepted
//               requests push the expected response (from a read-first
//               array model) into a queue; an independent monitor pops and
//               compares every response the DUT hands over.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_req_responder;

   logic       clk;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic       req_we;
   logic [3:0] req_addr;
   logic [3:0] req_wdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_we;
   logic [3:0] rsp_addr;
   logic [3:0] rsp_rdata;

   ram_req_responder #(.AW(4), .DW(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_we    (rsp_we),
      .rsp_addr  (rsp_addr),
      .rsp_rdata (rsp_rdata)
   );

   typedef struct {
      bit         we;
      logic [3:0] addr;
      logic [3:0] rdata;
      bit         chk_data;
      bit         chk_lat;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       e_acc;
   exp_t       e_mon;
   logic [3:0] mdl    [16];
   bit         mknown [16];

   int   checks   = 0;
   int   errors   = 0;
   int   cyc      = 0;
   bit   lat_mode = 0;
   bit   rnd_mode = 0;
   bit   hold_prev = 0;
   int   hold_val  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard producer: a handshake seen at the negedge completes at the
   // next posedge, so the model is updated here with read-first ordering.
   always @(negedge clk) begin
      if (rst_n && req_valid && req_ready) begin
         e_acc.we       = req_we;
         e_acc.addr     = req_addr;
         e_acc.rdata    = mdl[req_addr];
         e_acc.chk_data = mknown[req_addr];
         e_acc.chk_lat  = lat_mode;
         e_acc.cyc      = cyc;
         q.push_back(e_acc);
         if (req_we) begin
            mdl[req_addr]    = req_wdata;
            mknown[req_addr] = 1'b1;
         end
      end
   end

   // Monitor: checks response stability under stall and pops/compares on
   // every response handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         hold_prev = 1'b0;
      end else begin
         if (hold_prev) begin
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_payload", int'({rsp_we, rsp_addr, rsp_rdata}), hold_val);
         end
         hold_prev = rsp_valid && !rsp_ready;
         hold_val  = int'({rsp_we, rsp_addr, rsp_rdata});
         if (rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got addr %0d with no request pending", rsp_addr);
            end else begin
               e_mon = q.pop_front();
               chk("rsp_we", int'(rsp_we), int'(e_mon.we));
               chk("rsp_addr", int'(rsp_addr), int'(e_mon.addr));
               if (e_mon.chk_data) chk("rsp_rdata", int'(rsp_rdata), int'(e_mon.rdata));
               if (e_mon.chk_lat) chk("rsp_latency", cyc - e_mon.cyc, 1);
            end
         end
      end
   end

   // Pseudo-random downstream stall generator.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_mode) rsp_ready = 1'($urandom_range(0, 1));
      end
   end

   // Drive one request and hold it until accepted; returns cycles waited.
   task automatic send(input bit we, input logic [3:0] a, input logic [3:0] d,
                       output int waits);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      waits     = 0;
      @(negedge clk);
      while (!req_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: req_ready got 0 expected 1 within 200 cycles (addr %0d)", a);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Wait for every expected response to be delivered.
   task automatic drain();
      int n;
      n = 0;
      while ((q.size() != 0 || rsp_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0 || rsp_valid) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int w;
      for (int i = 0; i < 16; i++) begin
         mknown[i] = 1'b0;
         mdl[i]    = 4'h0;
      end
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 4'h0;
      req_wdata = 4'h0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_req_ready", int'(req_ready), 1);
      chk("reset_rsp_valid", int'(rsp_valid), 0);
      chk("reset_rsp_we", int'(rsp_we), 0);
      chk("reset_rsp_addr", int'(rsp_addr), 0);
      chk("reset_rsp_rdata", int'(rsp_rdata), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill: write addr^A everywhere, then read it all back, full rate
      lat_mode = 1'b1;
      for (int a = 0; a < 16; a++) begin
         send(1'b1, 4'(a), 4'(a) ^ 4'hA, w);
         chk("fill_wr_ready", w, 0);
      end
      for (int a = 0; a < 16; a++) begin
         send(1'b0, 4'(a), 4'h0, w);
         chk("fill_rd_ready", w, 0);
      end
      drain();
      lat_mode = 1'b0;

      // Read-first: mem[3] becomes 5, then write C expects old 5, read expects C
      send(1'b1, 4'd3, 4'h5, w);
      send(1'b1, 4'd3, 4'hC, w);
      send(1'b0, 4'd3, 4'h0, w);
      drain();

      // Backpressure: reads 0..3 with the consumer stalled
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 4'd0;
      @(negedge clk);
      chk("bp_ready_c1", int'(req_ready), 1);
      @(posedge clk);
      #1;
      req_addr = 4'd1;
      @(negedge clk);
      chk("bp_ready_c2", int'(req_ready), 1);
      chk("bp_valid_c2", int'(rsp_valid), 1);
      chk("bp_addr_c2", int'(rsp_addr), 0);
      @(posedge clk);
      #1;
      req_addr = 4'd2;
      @(negedge clk);
      chk("bp_ready_c3", int'(req_ready), 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         @(negedge clk);
         chk("bp_hold_ready", int'(req_ready), 0);
         chk("bp_hold_addr", int'(rsp_addr), 0);
         chk("bp_hold_rdata", int'(rsp_rdata), 4'hA);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      send(1'b0, 4'd2, 4'h0, w);
      send(1'b0, 4'd3, 4'h0, w);
      drain();

      // Random stall over mixed traffic
      rnd_mode = 1'b1;
      for (int n = 0; n < 200; n++) begin
         send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), w);
      end
      rnd_mode = 1'b0;
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      drain();

      // Reset with two responses outstanding
      rsp_ready = 1'b0;
      send(1'b1, 4'd5, 4'h7, w);
      send(1'b0, 4'd6, 4'h0, w);
      @(negedge clk);
      chk("prerst_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      q.delete();
      #1;
      chk("midrst_rsp_valid", int'(rsp_valid), 0);
      chk("midrst_req_ready", int'(req_ready), 1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      send(1'b0, 4'd5, 4'h0, w);   // expects 7 written before reset
      drain();

      // Same-address burst at 7: old (9), then 1, then 2
      send(1'b1, 4'd7, 4'h9, w);
      drain();
      send(1'b1, 4'd7, 4'h1, w);
      send(1'b1, 4'd7, 4'h2, w);
      send(1'b0, 4'd7, 4'h0, w);
      drain();

      chk("final_queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ram_req_responder
`default_nettype wire
